// File: rtl/clk_div_monitor.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// clk_div_monitor
//
// Purpose
//    Receives the divided 400 kHz clock (slow_clk) in the 40 MHz clk domain.
//    - Synchronises slow_clk through a flop chain.
//    - Emits single-cycle rise/fall strobes for use as clock enables downstream.
//    - Measures every half-period in clk cycles.
//    - Tracks lock, flags out-of-range half-periods while locked, and detects
//      loss of the slow clock.
//
// Ports
//    i_clk           in   1      40 MHz system clock
//    i_rst           in   1      synchronous reset, active-high
//    i_slow_clk      in   1      divided clock, asynchronous to i_clk
//    o_rise_pulse    out  1      1-cycle strobe per synchronised rising edge
//    o_fall_pulse    out  1      1-cycle strobe per synchronised falling edge
//    o_half_len      out  CNT_W  last measured half-period (clk cycles)
//    o_locked        out  1      monitor is in LOCKED
//    o_lost          out  1      monitor is in LOST
//    o_period_err    out  1      1-cycle strobe: out-of-range edge while LOCKED
//    o_err_cnt       out  8      number of period_err strobes, saturating at 255
// -----------------------------------------------------------------------------
module clk_div_monitor #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8,
   parameter int HALF_NOM    = 50,
   parameter int TOL         = 2,
   parameter int LOCK_EDGES  = 4,
   parameter int TIMEOUT     = 200
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_slow_clk,
   output logic             o_rise_pulse,
   output logic             o_fall_pulse,
   output logic [CNT_W-1:0] o_half_len,
   output logic             o_locked,
   output logic             o_lost,
   output logic             o_period_err,
   output logic [7:0]       o_err_cnt
);

   // ------------------------------------------------------------------------
   // Elaboration-time parameter sanity checks
   // ------------------------------------------------------------------------
   generate
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $error("clk_div_monitor: SYNC_STAGES must be at least 2");
      end
      if (TIMEOUT < 1 || TIMEOUT >= (1 << CNT_W)) begin : g_bad_timeout
         $error("clk_div_monitor: TIMEOUT must be in 1 .. 2**CNT_W-1");
      end
      if (LOCK_EDGES < 1) begin : g_bad_lock
         $error("clk_div_monitor: LOCK_EDGES must be at least 1");
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int GOOD_W = $clog2(LOCK_EDGES + 1);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

   // Range limits live in CNT_W+1 bits so cnt+1 never wraps; a lower limit
   // that would go negative is clamped to zero.
   localparam logic [CNT_W:0]   LO_LIM   = (HALF_NOM > TOL) ?
                                           (CNT_W+1)'(HALF_NOM - TOL) : '0;
   localparam logic [CNT_W:0]   HI_LIM   = (CNT_W+1)'(HALF_NOM + TOL);

   localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_EDGES - 1);
   localparam logic [7:0]        ERR_MAX   = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACQ    = 2'd1,
      ST_LOCKED = 2'd2,
      ST_LOST   = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // Synchroniser and edge detection
   // ------------------------------------------------------------------------
   // r_sync[0] is the metastability-catching stage; the last stage is the
   // first one any logic is allowed to look at.
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   w_s;
   logic                   w_edge;
   logic                   r_rise;
   logic                   r_fall;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_slow_clk};
      end
   end

   assign w_s    = r_sync[SYNC_STAGES-1];
   assign w_edge = w_s ^ r_prev;

   // Strobes are registered and independent of the monitor state, so the
   // downstream enable logic keeps running even while lock is lost.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_prev <= 1'b0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_prev <= w_s;
         r_rise <= w_s & ~r_prev;
         r_fall <= ~w_s & r_prev;
      end
   end

   // ------------------------------------------------------------------------
   // Half-period measurement
   // ------------------------------------------------------------------------
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_half_len;
   logic [CNT_W:0]   w_cnt_inc;
   logic             w_in_range;
   logic             w_timeout;

   // cnt counts the cycles elapsed since the last edge; the edge cycle
   // itself is included, hence the +1.
   assign w_cnt_inc  = {1'b0, r_cnt} + (CNT_W+1)'(1);
   assign w_in_range = (w_cnt_inc >= LO_LIM) && (w_cnt_inc <= HI_LIM);

   // An edge on the same cycle as the last timeout count restarts the
   // measurement instead of declaring the clock lost.
   assign w_timeout  = !w_edge && (r_cnt == TO_LAST);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt      <= '0;
         r_half_len <= '0;
      end else if (w_edge) begin
         // A saturated counter reports the largest representable length
         // rather than wrapping to zero.
         r_half_len <= w_cnt_inc[CNT_W] ? CNT_MAX : w_cnt_inc[CNT_W-1:0];
         r_cnt      <= '0;
      end else if (r_cnt != CNT_MAX) begin
         r_cnt      <= r_cnt + CNT_W'(1);
      end
   end

   // ------------------------------------------------------------------------
   // Lock FSM
   // ------------------------------------------------------------------------
   state_t            r_state;
   state_t            w_state_next;
   logic [GOOD_W-1:0] r_good;
   logic [GOOD_W-1:0] w_good_next;
   logic              r_period_err;
   logic              w_period_err_next;
   logic [7:0]        r_err_cnt;

   always_comb begin
      w_state_next      = r_state;
      w_good_next       = r_good;
      w_period_err_next = 1'b0;

      case (r_state)
         ST_IDLE: begin
            // The first edge after reset only starts a measurement; the
            // length it closes is not trusted for acquisition.
            if (w_edge) begin
               w_state_next = ST_ACQ;
               w_good_next  = '0;
            end else if (w_timeout) begin
               w_state_next = ST_LOST;
            end
         end

         ST_ACQ: begin
            if (w_edge) begin
               if (w_in_range) begin
                  w_good_next = r_good + GOOD_W'(1);
                  if (r_good == GOOD_LAST) begin
                     w_state_next = ST_LOCKED;
                  end
               end else begin
                  // A single bad half-period restarts the run of good ones.
                  w_good_next = '0;
               end
            end else if (w_timeout) begin
               w_state_next = ST_LOST;
            end
         end

         ST_LOCKED: begin
            if (w_edge) begin
               if (!w_in_range) begin
                  w_state_next      = ST_ACQ;
                  w_good_next       = '0;
                  w_period_err_next = 1'b1;
               end
            end else if (w_timeout) begin
               // Loss of clock is reported through lost, not period_err.
               w_state_next = ST_LOST;
            end
         end

         ST_LOST: begin
            // The reappearing edge updates half_len but is not counted.
            if (w_edge) begin
               w_state_next = ST_ACQ;
               w_good_next  = '0;
            end
         end

         default: begin
            w_state_next = ST_IDLE;
            w_good_next  = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_good       <= '0;
         r_period_err <= 1'b0;
         r_err_cnt    <= '0;
      end else begin
         r_state      <= w_state_next;
         r_good       <= w_good_next;
         r_period_err <= w_period_err_next;
         if (w_period_err_next && (r_err_cnt != ERR_MAX)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs: everything comes straight from registers or a decode of the
   // registered state, so none of them can glitch.
   // ------------------------------------------------------------------------
   assign o_rise_pulse = r_rise;
   assign o_fall_pulse = r_fall;
   assign o_half_len   = r_half_len;
   assign o_locked     = (r_state == ST_LOCKED);
   assign o_lost       = (r_state == ST_LOST);
   assign o_period_err = r_period_err;
   assign o_err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_clk_div_monitor.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_clk_div_monitor
//
// Drives slow_clk as a sequence of half-periods of chosen length and predicts
// every output cycle by cycle from event timestamps: each toggle of slow_clk
// becomes a strobe three clk edges later, the half-period is the distance
// between successive strobes, and the lock state follows from the sequence of
// measured lengths.
// -----------------------------------------------------------------------------
module tb_clk_div_monitor;

   localparam int HALF_NOM   = 50;
   localparam int TOL        = 2;
   localparam int LOCK_EDGES = 4;
   localparam int TIMEOUT    = 200;
   localparam int LATENCY    = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       slow_clk = 1'b0;
   logic       rise_pulse;
   logic       fall_pulse;
   logic [7:0] half_len;
   logic       locked;
   logic       lost;
   logic       period_err;
   logic [7:0] err_cnt;

   clk_div_monitor dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_slow_clk   (slow_clk),
      .o_rise_pulse (rise_pulse),
      .o_fall_pulse (fall_pulse),
      .o_half_len   (half_len),
      .o_locked     (locked),
      .o_lost       (lost),
      .o_period_err (period_err),
      .o_err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // ---------------- reference model ----------------
   typedef enum int {M_IDLE, M_ACQ, M_LOCKED, M_LOST} mstate_t;
   mstate_t m_state = M_IDLE;
   int      m_last  = 0;     // cycle of last strobe (or reset)
   int      m_good  = 0;
   int      m_err   = 0;
   int      m_half  = 0;
   bit      e_rise  = 0;
   bit      e_fall  = 0;
   bit      e_perr  = 0;
   int      q_time[$];
   bit      q_rise[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_edge();
      int gap;
      bit inr;
      gap = cyc - m_last;
      e_rise = q_rise[0];
      e_fall = !q_rise[0];
      void'(q_time.pop_front());
      void'(q_rise.pop_front());
      m_half = (gap > 255) ? 255 : gap;
      inr = (gap >= HALF_NOM - TOL) && (gap <= HALF_NOM + TOL);
      case (m_state)
         M_IDLE, M_LOST: begin
            m_state = M_ACQ;
            m_good  = 0;
         end
         M_ACQ: begin
            if (inr) begin
               m_good++;
               if (m_good >= LOCK_EDGES) m_state = M_LOCKED;
            end else begin
               m_good = 0;
            end
         end
         default: begin
            if (!inr) begin
               m_state = M_ACQ;
               m_good  = 0;
               e_perr  = 1;
               if (m_err < 255) m_err++;
            end
         end
      endcase
      m_last = cyc;
   endtask

   task automatic model_posedge();
      e_rise = 0;
      e_fall = 0;
      e_perr = 0;
      if (rst) begin
         m_state = M_IDLE;
         m_good  = 0;
         m_err   = 0;
         m_half  = 0;
         m_last  = cyc;
         q_time.delete();
         q_rise.delete();
         // The cleared synchroniser re-samples the current level.
         if (slow_clk) begin
            q_time.push_back(cyc + LATENCY);
            q_rise.push_back(1'b1);
         end
      end else if (q_time.size() > 0 && q_time[0] == cyc) begin
         model_edge();
      end else if (cyc - m_last == TIMEOUT && m_state != M_LOST) begin
         m_state = M_LOST;
      end
   endtask

   // One clock: advance, update model, compare all outputs 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      cyc++;
      model_posedge();
      #1;
      chk("rise_pulse", rise_pulse, e_rise);
      chk("fall_pulse", fall_pulse, e_fall);
      chk("half_len",   half_len,   m_half);
      chk("locked",     locked,     m_state == M_LOCKED);
      chk("lost",       lost,       m_state == M_LOST);
      chk("period_err", period_err, e_perr);
      chk("err_cnt",    err_cnt,    m_err);
   endtask

   task automatic toggle();
      slow_clk = ~slow_clk;
      q_time.push_back(cyc + LATENCY);
      q_rise.push_back(slow_clk);
   endtask

   task automatic half(input int n);
      toggle();
      repeat (n) step();
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle(5);
   endtask

   initial begin
      // Reset
      rst = 1'b1;
      step();
      step();
      chk("rst_half_len", half_len, 0);
      chk("rst_locked", locked, 0);
      rst = 1'b0;
      idle(5);

      // 1: ideal divider, lock after 1+4 edges
      repeat (12) half(50);
      chk("t1_half_len", half_len, 50);
      chk("t1_locked", locked, 1);

      // 2: one long half-period while locked
      half(54);
      repeat (8) half(50);
      chk("t2_err_cnt", err_cnt, 1);
      chk("t2_relocked", locked, 1);

      // 3: limits in range, one past limits out of range
      repeat (3) begin half(48); half(52); end
      chk("t3_lock_held", locked, 1);
      half(47);
      repeat (6) half(50);
      half(53);
      repeat (6) half(50);
      chk("t3_err_cnt", err_cnt, 3);

      // 4: slow_clk stops low, then restarts
      if (slow_clk) half(50);
      idle(250);
      chk("t4_lost", lost, 1);
      repeat (8) half(50);
      chk("t4_relocked", locked, 1);

      // 5: edge exactly on the last timeout count (from ACQ), then one later
      half(30);
      half(200);
      chk("t5_not_lost", lost, 0);
      half(201);
      repeat (8) half(50);

      // 6: reset mid-lock
      do_reset();
      chk("t6_err_cnt_clr", err_cnt, 0);
      chk("t6_unlocked", locked, 0);

      // Randomised half-periods around nominal, occasional long gaps
      repeat (60) begin
         if ($urandom_range(0, 9) == 0) half($urandom_range(190, 215));
         else half($urandom_range(44, 56));
      end

      // err_cnt saturation: lock, then alternate bad edge and relock
      repeat (6) half(50);
      repeat (258) begin
         if ($urandom_range(0, 1) == 0) half($urandom_range(2, 47));
         else half($urandom_range(53, 70));
         repeat (4) half($urandom_range(48, 52));
      end
      chk("t6_err_sat", err_cnt, 255);
      idle(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
